// File: rtl/uart_pkg.sv
// Shared UART definitions: receive word width, the {error, data} FIFO entry, and
// default receive-FIFO sizing.
package uart_pkg;

   localparam int unsigned UART_DATA_W   = 9;
   localparam int unsigned RX_FIFO_DEPTH = 16;
   localparam int unsigned RX_FIFO_AFULL = 12;

   typedef struct packed {
      logic                   error;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register file: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with fill level, almost-full warning and a
// sticky overflow flag. Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = UART_DATA_W,
   parameter int unsigned DEPTH        = RX_FIFO_DEPTH,
   parameter int unsigned AFULL_THRESH = RX_FIFO_AFULL
) (
   input  logic                     rxclk,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_error,
   input  logic                     flush,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_error,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overflow,
   input  logic                     overflow_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic            full;
   logic            rd_hs;
   logic            wr_acc;
   logic            ovf_evt;
   logic [DATA_W:0] head;

   // Status is decoded purely from registered pointers.
   assign rd_valid    = (wr_ptr_q != rd_ptr_q);
   assign full        = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
   assign count       = wr_ptr_q - rd_ptr_q;
   assign almost_full = (count >= PW'(AFULL_THRESH));
   assign overflow    = overflow_q;

   assign rd_hs   = rd_valid && rd_ready;
   assign wr_acc  = wr_valid && (!full || rd_hs) && !flush;
   assign ovf_evt = wr_valid && full && !rd_hs && !flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_hs)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Set wins over clear when both happen in one cycle.
      if (ovf_evt) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   uart_fifo_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (rxclk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata ({wr_error, wr_data}),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (head)
   );

   assign rd_data  = rd_valid ? head[DATA_W-1:0] : '0;
   assign rd_error = rd_valid & head[DATA_W];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int unsigned DW    = 9;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 12;

   logic          rxclk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_error = 1'b0;
   logic          flush = 1'b0;
   logic          rd_ready = 1'b0;
   logic          overflow_clr = 1'b0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_error;
   logic [4:0]    count;
   logic          almost_full;
   logic          overflow;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   uart_rx_fifo #(
      .DATA_W       (DW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF)
   ) dut (
      .rxclk        (rxclk),
      .reset_n      (reset_n),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_error     (wr_error),
      .flush        (flush),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_error     (rd_error),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 rxclk = ~rxclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered queue of entries and an overflow bit.
   rx_entry_t m_q[$];
   bit        m_ovf = 1'b0;

   always @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         bit hs;
         bit evt;
         hs  = (m_q.size() > 0) && rd_ready;
         evt = 1'b0;
         if (flush) begin
            m_q.delete();
         end else begin
            if (wr_valid && m_q.size() == DEPTH && !hs) evt = 1'b1;
            if (hs) void'(m_q.pop_front());
            if (wr_valid && m_q.size() < DEPTH) m_q.push_back(rx_entry_t'({wr_error, wr_data}));
         end
         if (evt) m_ovf = 1'b1;
         else if (overflow_clr) m_ovf = 1'b0;
      end
   end

   always @(negedge rxclk) begin
      if (cmp_en) begin
         int sz;
         sz = m_q.size();
         check("m_rd_valid", 32'(rd_valid), 32'(sz > 0));
         check("m_rd_data", 32'(rd_data), (sz > 0) ? 32'(m_q[0].data) : 32'd0);
         check("m_rd_error", 32'(rd_error), (sz > 0) ? 32'(m_q[0].error) : 32'd0);
         check("m_count", 32'(count), 32'(sz));
         check("m_almost_full", 32'(almost_full), 32'(sz >= AF));
         check("m_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge rxclk);
      #1;
   endtask

   task automatic write(input logic [DW-1:0] d, input logic e);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_error = e;
      tick();
      wr_valid = 1'b0;
      wr_error = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
      check({tag, "_rd_error"}, 32'(rd_error), 32'd0);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      #12;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      tick();
      cmp_en = 1'b1;

      // Single word in, single word out.
      write(9'h1A5, 1'b0);
      check("t1_rd_valid", 32'(rd_valid), 32'd1);
      check("t1_rd_data", 32'(rd_data), 32'h1A5);
      check("t1_count", 32'(count), 32'd1);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("t1_rd_valid_after", 32'(rd_valid), 32'd0);
      check("t1_count_after", 32'(count), 32'd0);

      // Fill to full, then overflow.
      for (int i = 0; i < 16; i++) begin
         write(DW'(i), 1'b0);
         if (i == 10) check("af_after_11", 32'(almost_full), 32'd0);
         if (i == 11) check("af_after_12", 32'(almost_full), 32'd1);
      end
      check("full_count", 32'(count), 32'd16);
      check("full_ovf_before", 32'(overflow), 32'd0);
      write(9'h1FF, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd16);

      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);

      // Write and read together while full.
      rd_ready = 1'b1;
      write(9'h0AA, 1'b0);
      rd_ready = 1'b0;
      check("full_rw_count", 32'(count), 32'd16);
      check("full_rw_ovf", 32'(overflow), 32'd0);

      rd_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("drain_data", 32'(rd_data), (i == 16) ? 32'h0AA : 32'(i));
         tick();
      end
      rd_ready = 1'b0;
      check("drain_empty", 32'(rd_valid), 32'd0);

      // 40 back-to-back writes with continuous reads; pointers wrap.
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] d;
         logic          e;
         d = DW'((i * 13 + 7) % 512);
         e = (i == 3) || (i == 37);
         write(d, e);
         check("b2b_data", 32'(rd_data), 32'(d));
         check("b2b_error", 32'(rd_error), 32'(e));
         check("b2b_count", 32'(count), 32'd1);
      end
      tick();
      rd_ready = 1'b0;
      check("b2b_empty", 32'(count), 32'd0);

      // Flush beats a simultaneous write and read.
      for (int i = 0; i < 5; i++) write(DW'(9'h100 + i), 1'b0);
      check("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1;
      rd_ready = 1'b1;
      write(9'h055, 1'b0);
      flush = 1'b0;
      rd_ready = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_rd_valid", 32'(rd_valid), 32'd0);
      check("flush_ovf", 32'(overflow), 32'd0);

      // Overflow set beats a same-cycle clear; flush leaves it set.
      for (int i = 0; i < 16; i++) write(DW'(9'h080 + i), 1'b1);
      overflow_clr = 1'b1;
      write(9'h0F0, 1'b0);
      overflow_clr = 1'b0;
      check("set_wins", 32'(overflow), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_keeps_ovf", 32'(overflow), 32'd1);
      check("flush2_count", 32'(count), 32'd0);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;

      // Asynchronous reset mid-stream with 7 entries stored.
      for (int i = 0; i < 7; i++) write(DW'(9'h040 + i), i[0]);
      check("pre_reset_count", 32'(count), 32'd7);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge rxclk);
      #1;
      reset_n = 1'b1;
      tick();
      check("post_reset_count", 32'(count), 32'd0);
      check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
      tick();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
